// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte input; each bit is held DIVISOR = CLKRATE/BAUDRATE clocks.
// Optional even parity bit after the data bits: define UART_TX_PARITY_EN.
module uart_tx #(
  parameter int CLKRATE  = 12_000_000,
  parameter int BAUDRATE = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int DIVISOR = CLKRATE / BAUDRATE;
  localparam int CNT_W   = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIVISOR - 1);

  generate
    if (DIVISOR < 2) begin : g_bad_divisor
      $error("uart_tx: CLKRATE/BAUDRATE must be at least 2");
    end
  endgenerate

  // Handshake: a byte is taken on a rising edge where valid && ready; ready is
  // high only in IDLE, so valid offered while a frame is running is ignored.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             tx_q, tx_d;
  logic             bit_done;

  assign bit_done = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    tx_d    = tx_q;

    if (state_q != IDLE) begin
      cnt_d = bit_done ? CNT_RELOAD : cnt_q - CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (valid) begin
          byte_d  = data;
          state_d = START;
          tx_d    = 1'b0;
          cnt_d   = CNT_RELOAD;
          idx_d   = 3'd0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          tx_d    = byte_q[0];
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^byte_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = byte_q[idx_q + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        cnt_d   = '0;
        idx_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      byte_q  <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);
  assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at CLKRATE=16, BAUDRATE=1 (16 clocks per bit);
// define UART_TX_PARITY_EN to build both bench and design with the parity bit.
module tb_uart_tx;

  localparam int D = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'd0;
  logic       valid = 1'b0;
  logic       ready, tx, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0] exp_q[$];

  uart_tx #(.CLKRATE(16), .BAUDRATE(1)) dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid),
    .ready(ready), .tx(tx), .busy(busy)
  );

  // clock / cycle counter / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic [NB-1:0] frame_bits(input logic [7:0] b);
    logic [NB-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = (((b >> i) & 8'd1) != 8'd0);
`ifdef UART_TX_PARITY_EN
    f[9] = ($countones(b) % 2) == 1;
`endif
    f[NB-1] = 1'b1;
    return f;
  endfunction

  // monitor: detects start bits, pops the expected byte, checks every sample of every bit
  logic          mon_active = 1'b0;
  logic          mon_idle_chk = 1'b0;
  logic          prev_tx = 1'b1;
  logic [NB-1:0] exp_bits;
  logic [7:0]    exp_b;
  int            bit_i, cnt_i, start_cyc, bad_tx;
  int            last_stop_cyc = -1000;
  int            last_gap = -1;
  logic          bit_ok, ctl_ok;

  always @(negedge clk) begin
    if (rst) begin
      mon_active   = 1'b0;
      mon_idle_chk = 1'b0;
    end else begin
      if (mon_idle_chk) begin
        check("idle_after_stop {tx,ready,busy}", int'({tx, ready, busy}), 3'b110);
        mon_idle_chk = 1'b0;
      end
      if (!mon_active && prev_tx && !tx) begin
        start_cyc = cyc;
        last_gap  = start_cyc - last_stop_cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          exp_b      = exp_q.pop_front();
          exp_bits   = frame_bits(exp_b);
          mon_active = 1'b1;
          bit_i      = 0;
          cnt_i      = 0;
          bit_ok     = 1'b1;
          ctl_ok     = 1'b1;
          bad_tx     = 0;
        end
      end
      if (mon_active) begin
        if (tx !== exp_bits[bit_i]) begin
          bit_ok = 1'b0;
          bad_tx = int'(tx);
        end
        if (ready !== 1'b0 || busy !== 1'b1) ctl_ok = 1'b0;
        cnt_i++;
        if (cnt_i == D) begin
          check($sformatf("frame_%02h_bit%0d", exp_b, bit_i),
                bit_ok ? int'(exp_bits[bit_i]) : bad_tx, int'(exp_bits[bit_i]));
          bit_ok = 1'b1;
          cnt_i  = 0;
          bit_i++;
          if (bit_i == NB - 1) last_stop_cyc = start_cyc + (NB - 1) * D;
          if (bit_i == NB) begin
            check($sformatf("frame_%02h_ready_low_busy_high", exp_b), int'(ctl_ok), 1);
            mon_active   = 1'b0;
            mon_idle_chk = 1'b1;
          end
        end
      end
    end
    prev_tx = tx;
  end

  // driver tasks
  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 4 * D * NB) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) check("ready_timeout", int'(ready), 1);
  endtask

  task automatic send(input logic [7:0] b, input bit keep);
    @(negedge clk);
    wait_ready();
    data  = b;
    valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(b);
    #1;
    if (!keep) valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || mon_active || busy) && n < 4 * D * NB) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || mon_active || busy) check("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    bit keep;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", int'(tx), 1);
    check("reset_ready", int'(ready), 1);
    check("reset_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // alternating pattern, then parity odd/even cases
    send(8'h55, 1'b0);
    wait_done();
    send(8'h07, 1'b0);
    wait_done();
    send(8'h03, 1'b0);
    wait_done();

    // valid held: back-to-back frames with one IDLE clock between them
    send(8'hA3, 1'b1);
    send(8'h0F, 1'b0);
    wait_done();
    check("b2b_gap_clocks", last_gap, D + 1);

    // reset 50 clocks into a frame aborts it; the next byte is clean
    send(8'h00, 1'b0);
    repeat (49) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_tx", int'(tx), 1);
    check("abort_ready", int'(ready), 1);
    check("abort_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    send(8'hFF, 1'b0);
    wait_done();

    // reset wins over a simultaneous handshake
    @(negedge clk);
    wait_ready();
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'h5A;
    @(posedge clk);
    #1;
    valid = 1'b0;
    check("rst_priority_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3 * D) @(negedge clk);
    check("rst_priority_no_frame", int'(busy), 0);

    // data scrambled and valid pulsed during a frame
    send(8'h81, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      data  = 8'($urandom);
      valid = (i >= 10 && i < 20);
    end
    valid = 1'b0;
    for (int i = 0; i < 4 * D * NB && busy; i++) begin
      @(negedge clk);
      data = 8'($urandom);
    end
    wait_done();
    repeat (2 * D) @(negedge clk);
    check("no_extra_frame_busy", int'(busy), 0);

    // randomized bytes, random back-to-back or idle gaps
    for (int i = 0; i < 16; i++) begin
      b    = 8'($urandom_range(0, 255));
      keep = (i != 15) && ($urandom_range(0, 1) == 1);
      send(b, keep);
      if (!keep) repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    wait_done();
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKRATE, default 12_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 300, serial bit rate in baud.
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port data, input, 8, byte to transmit, sampled at handshake.
REQ-006 SHALL have port valid, input, 1, producer offers data.
REQ-007 SHALL have port ready, output, 1, block accepts data this cycle.
REQ-008 SHALL have port tx, output, 1, serial line, idle high, registered.
REQ-009 SHALL have port busy, output, 1, high while a frame is on the line.

Function
REQ-010 SHALL define DIVISOR = CLKRATE/BAUDRATE (integer division), which is 40000 at defaults; DIVISOR < 2 is illegal and SHALL halt elaboration.
REQ-011 SHALL use states IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-012 SHALL assert ready only in IDLE; handshake = valid && ready on a rising clk edge.
REQ-013 On handshake SHALL latch data, enter START, and drive tx=0 from the next edge; data changes after handshake SHALL NOT affect the frame.
REQ-014 SHALL hold every bit on tx for exactly DIVISOR clocks, using a baud counter that reloads at each bit boundary.
REQ-015 DATA SHALL send 8 bits LSB first; a 3-bit index SHALL advance at each bit boundary; leaving DATA after index 7.
REQ-016 STOP SHALL drive tx=1 for DIVISOR clocks, then return to IDLE.
REQ-017 Frame length SHALL be 10*DIVISOR clocks without parity and 11*DIVISOR clocks with parity.
REQ-018 busy SHALL be high in every non-IDLE state and low in IDLE.
REQ-019 If valid is held high, the next frame's start bit SHALL begin DIVISOR+1 clocks after the previous stop bit began: one IDLE cycle, no extra gap.
REQ-020 valid without ready SHALL be ignored, with no queueing; valid deasserting mid-frame SHALL NOT affect the frame.
REQ-021 tx SHALL NOT glitch at state transitions because it is driven from a register only.

Reset
REQ-022 rst SHALL force, at the next clk edge, state=IDLE, tx=1, ready=1, busy=0, baud counter=0 and bit index=0.
REQ-023 rst asserted mid-frame SHALL abort the frame; tx SHALL be 1 from the first edge with rst high.
REQ-024 rst SHALL take priority over a simultaneous handshake; the offered byte is dropped.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: PARITY state after DATA sends the even-parity bit (XOR of the 8 data bits) for DIVISOR clocks.
REQ-026 Macro UART_TX_PARITY_EN undefined: no PARITY state; DATA goes directly to STOP; no parity logic synthesized.

Verification
REQ-027 Set CLKRATE=16, BAUDRATE=1, no parity; send 0x55 -> tx reads 0,1,0,1,0,1,0,1,0,1, each bit 16 clocks; frame lasts 160 clocks; ready low throughout.
REQ-028 Same parameters; hold valid, sending 0xA3 then 0x0F -> two back-to-back frames separated by exactly 1 IDLE clock; decoded bytes are 0xA3 and 0x0F.
REQ-029 Same parameters, UART_TX_PARITY_EN defined; send 0x07 -> parity bit=1, frame lasts 176 clocks; send 0x03 -> parity bit=0.
REQ-030 Assert rst for 1 clock at clock 50 of a 0x00 frame -> tx=1 and ready=1 from that edge; the next byte, 0xFF, transmits correctly.
REQ-031 Change data every clock after the handshake of 0x81 -> 0x81 is transmitted; valid pulsed while busy -> no extra frame.
REQ-032 Default parameters -> each bit lasts 40000 clocks (3.333 ms at 12 MHz).
